inst_encoder_loader: RTL

Assembles RV32I instructions from field-level requests and writes them sequentially into instruction memory, acting as the encoding counterpart to the decode path's immediate generator. Sits between a test/boot program source and the instruction-memory write port. Checks every immediate for range and alignment before packing it. One request is accepted, encoded into a register, then held on a stallable write port until memory accepts it.

---
 rtl/inst_encoder_loader_if.sv | 33 +++
 rtl/inst_encoder_loader.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/inst_encoder_loader_if.sv
// Request and instruction-memory write handshake bundle for inst_encoder_loader.
//   req_*  : field-level instruction request from the program source
//   wr_*   : stallable write port toward instruction memory
// master : program source / memory side (drives requests and wr_ready)
// slave  : the encoder/loader
interface inst_encoder_loader_if;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_opcode;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [31:0] req_imm;
    logic        req_last;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport master (
        output req_valid, req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7,
               req_imm, req_last, wr_ready,
        input  req_ready, wr_valid, wr_addr, wr_data
    );

    modport slave (
        input  req_valid, req_opcode, req_rd, req_rs1, req_rs2, req_funct3, req_funct7,
               req_imm, req_last, wr_ready,
        output req_ready, wr_valid, wr_addr, wr_data
    );
endinterface

// File: rtl/inst_encoder_loader.sv
// RV32I instruction encoder and sequential instruction-memory loader.
// Accepts one field-level request, range/alignment-checks the immediate, packs the
// instruction into a register and holds it on the write port until memory accepts it.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   bus        : request + write handshake (slave modport)
//   done       : last request fully retired (held until reset)
//   err        : sticky error flag
//   err_code   : first error, 01 = bad immediate, 10 = unknown opcode
//   inst_count : number of writes accepted by memory (wraps at 2^32)
module inst_encoder_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    inst_encoder_loader_if.slave     bus,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [31:0]              inst_count
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWrite = 2'd1;
    localparam logic [1:0] StDone  = 2'd2;

    localparam logic [6:0] OpArith    = 7'b0110011;
    localparam logic [6:0] OpArithImm = 7'b0010011;
    localparam logic [6:0] OpLoad     = 7'b0000011;
    localparam logic [6:0] OpJalr     = 7'b1100111;
    localparam logic [6:0] OpStore    = 7'b0100011;
    localparam logic [6:0] OpBranch   = 7'b1100011;
    localparam logic [6:0] OpJal      = 7'b1101111;
    localparam logic [6:0] OpSystem   = 7'b1110011;

    logic [1:0]      state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [31:0]     data_q, data_d;
    logic            last_q, last_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic [31:0]     cnt_q, cnt_d;

    logic [31:0]        enc;
    logic               imm_ok;
    logic               op_ok;
    logic signed [31:0] imm_s;
    logic [31:0]        imm;

    assign imm   = bus.req_imm;
    assign imm_s = $signed(bus.req_imm);

    // Combinational encoder and immediate legality check.
    always_comb begin
        enc    = '0;
        imm_ok = 1'b1;
        op_ok  = 1'b1;
        case (bus.req_opcode)
            OpArith: begin
                enc = {bus.req_funct7, bus.req_rs2, bus.req_rs1, bus.req_funct3, bus.req_rd,
                       bus.req_opcode};
            end
            OpArithImm, OpLoad, OpJalr: begin
                imm_ok = (imm_s >= -2048) && (imm_s <= 2047);
                enc    = {imm[11:0], bus.req_rs1, bus.req_funct3, bus.req_rd, bus.req_opcode};
            end
            OpStore: begin
                imm_ok = (imm_s >= -2048) && (imm_s <= 2047);
                enc    = {imm[11:5], bus.req_rs2, bus.req_rs1, bus.req_funct3, imm[4:0],
                          bus.req_opcode};
            end
            OpBranch: begin
                imm_ok = (imm_s >= -4096) && (imm_s <= 4094) && !imm[0];
                enc    = {imm[12], imm[10:5], bus.req_rs2, bus.req_rs1, bus.req_funct3,
                          imm[4:1], imm[11], bus.req_opcode};
            end
            OpJal: begin
                imm_ok = (imm_s >= -1048576) && (imm_s <= 1048574) && !imm[0];
                enc    = {imm[20], imm[10:1], imm[11], imm[19:12], bus.req_rd, bus.req_opcode};
            end
            OpSystem: begin
                enc = 32'h0000_0073;
            end
            default: begin
                op_ok = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;
        err_d   = err_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    if (!op_ok || !imm_ok) begin
                        // Bad request is consumed without a write; only the first error
                        // code is kept.
                        err_d = 1'b1;
                        if (!err_q) begin
                            code_d = op_ok ? 2'b01 : 2'b10;
                        end
                        if (bus.req_last) begin
                            state_d = StDone;
                        end
                    end else begin
                        data_d  = enc;
                        last_d  = bus.req_last;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (bus.wr_ready) begin
                    idx_d   = (idx_q == IdxW'(DEPTH_WORDS - 1)) ? '0 : idx_q + 1'b1;
                    cnt_d   = cnt_q + 32'd1;
                    state_d = last_q ? StDone : StIdle;
                end
            end
            StDone: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            last_q  <= last_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.wr_valid  = (state_q == StWrite);
    assign bus.wr_addr   = BASE_ADDR + (32'(idx_q) << 2);
    assign bus.wr_data   = data_q;
    assign done          = (state_q == StDone);
    assign err           = err_q;
    assign err_code      = code_q;
    assign inst_count    = cnt_q;

endmodule
